cnn_pixel_streamer: RTL and testbench
=====================================

Name: cnn_pixel_streamer

Overview:
Input-side stimulus source for simpleCNN. It buffers one image written through a simple write port. On a start pulse it streams the pixels in raster order, with optional zero padding, over a valid/ready handshake into the convolution layer. It reports progress through the count, out_last and frame_done outputs, so a frame can be fed in and the CNN's prob/fc_done outputs observed against a known pixel order.

Parameters:
IMG_W, 28, image width in pixels.
IMG_H, 28, image height in pixels.
PIX_W, 8, pixel width in bits (unsigned).
PAD, 0, zero-padding border width on every side (0..3).
ADDR_W, 10, buffer address width; 2^ADDR_W >= IMG_W*IMG_H.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous active-low reset.
wr_en  in  1  buffer write strobe.
wr_addr  in  ADDR_W  pixel address, raster order (row*IMG_W+col).
wr_data  in  PIX_W  pixel value.
start  in  1  begin streaming one frame.
out_ready  in  1  downstream can accept.
out_valid  out  1  out_data/out_row/out_col/out_last valid.
out_data  out  PIX_W  pixel value (0 in pad region).
out_row  out  8  padded-frame row index.
out_col  out  8  padded-frame column index.
out_last  out  1  marks final beat of the frame.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse after the last beat.
count  out  16  accepted beats in the current or last frame.
wr_err  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Frame geometry: FW=IMG_W+2*PAD, FH=IMG_H+2*PAD, N=FW*FH beats. Order is row-major: row 0..FH-1, col 0..FW-1.
- Reset (rst=0 at a clk edge):
  - state goes to IDLE.
  - out_valid, out_last, busy, frame_done and wr_err go to 0.
  - out_data, out_row, out_col and count go to 0.
  - Buffer contents are NOT cleared.
- States: IDLE, PRIME, STREAM.
  - IDLE: busy=0.
    - start=1 moves to PRIME: count cleared to 0, busy=1 next cycle.
  - PRIME: one-cycle buffer read latency; moves to STREAM with out_valid=1.
    - First beat is visible 2 cycles after start is sampled.
  - STREAM: a beat transfers when out_valid&&out_ready; count increments on each transfer.
    - Transfer of beat N: out_valid=0 and state goes to IDLE next cycle.
    - In that same cycle frame_done=1 and busy=0.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last hold stable.
  - With out_ready held high, throughput is 1 beat/cycle with no bubbles. The buffer read is prefetched; a skid register is permitted.
- Pad region: row<PAD, row>=PAD+IMG_H, col<PAD or col>=PAD+IMG_W gives out_data=0.
- Interior region: out_data=buffer[(row-PAD)*IMG_W+(col-PAD)].
- out_last=1 only on the beat with row=FH-1 and col=FW-1.
- Writes:
  - Accepted only in IDLE with wr_addr < IMG_W*IMG_H.
  - Otherwise (busy, or out of range) the write is dropped and wr_err=1 on the next cycle for one cycle.
  - A write and start in the same IDLE cycle: the write is committed before streaming; the frame sees the new value.
- start while busy is ignored.
- start in the frame_done cycle (state IDLE) is accepted: a back-to-back frame begins with no extra idle cycle.
- count holds its final value (N) after the frame until the next start.
- Reset mid-frame: the stream aborts immediately, no frame_done is issued, and the next start replays from beat 0 using the preserved buffer.

Test Plan:
1. Default params. Write buffer[i]=i mod 256 for i=0..783, start, out_ready=1 -> first valid 2 cycles after start; 784 consecutive beats with out_data=i mod 256; out_last only on beat 784 (row 27, col 27); frame_done pulses the next cycle; count=784; busy=0.
2. Same frame with out_ready pattern 1,0,1,0 and held low 5 cycles at beat 100 -> fields stable while stalled, received sequence identical to scenario 1, count=784.
3. PAD=1 instance, same ramp data -> 900 beats; beats 0..30 are zero; beat 31 (row 1, col 1)=0x00; beat 32=0x01; last interior beat (row 28, col 28)=783 mod 256=0x0F; count=900.
4. wr_en during streaming at addr 5 with data 0xAA, and in IDLE at addr 784 -> wr_err pulses each time, no busy change; the next frame shows buffer[5]=0x05.
5. rst=0 for 1 cycle at beat 300 -> next edge has out_valid=0, busy=0, count=0 and no frame_done; a new start replays the full ramp from 0.
6. start asserted in the frame_done cycle -> second frame's first beat appears 2 cycles later; count restarts at 0; two frame_done pulses total.

Source files
------------

// File: rtl/cnn_pixel_streamer.sv
// Frame buffer plus raster streamer feeding simpleCNN over valid/ready.
// The beat register loads one pixel per accepted beat, with optional zero padding.
module cnn_pixel_streamer #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned PAD    = 0,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_data,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       count,
  output logic              wr_err
);

  localparam int unsigned FW    = IMG_W + 2 * PAD;
  localparam int unsigned FH    = IMG_H + 2 * PAD;
  localparam int unsigned N_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  logic [PIX_W-1:0] mem [N_PIX];

  state_t            state_q, state_d;
  logic              fire_c, load_c, wr_ok_c, interior_c;
  logic [7:0]        nxt_row_c, nxt_col_c, ld_row_c, ld_col_c, rr_c, cc_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [PIX_W-1:0]  rd_data_c;
  logic              valid_d, last_d, busy_d, done_d;
  logic [15:0]       count_d;
  logic [7:0]        row_d, col_d;
  logic [PIX_W-1:0]  data_d;

  assign wr_ok_c = wr_en && (state_q == IDLE) && (32'(wr_addr) < N_PIX);

  // Buffer contents survive reset so a frame can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = out_valid;
    last_d    = out_last;
    busy_d    = busy;
    done_d    = 1'b0;
    count_d   = count;
    row_d     = out_row;
    col_d     = out_col;
    data_d    = out_data;
    load_c    = 1'b0;
    fire_c    = out_valid && out_ready;

    if (out_col == 8'(FW - 1)) begin
      nxt_row_c = out_row + 8'd1;
      nxt_col_c = 8'd0;
    end else begin
      nxt_row_c = out_row;
      nxt_col_c = out_col + 8'd1;
    end
    ld_row_c = (state_q == PRIME) ? 8'd0 : nxt_row_c;
    ld_col_c = (state_q == PRIME) ? 8'd0 : nxt_col_c;

    // Pad rows/cols wrap below zero, so a single unsigned bound covers both sides.
    rr_c       = ld_row_c - 8'(PAD);
    cc_c       = ld_col_c - 8'(PAD);
    interior_c = (rr_c < 8'(IMG_H)) && (cc_c < 8'(IMG_W));
    rd_addr_c  = ADDR_W'(rr_c) * ADDR_W'(IMG_W) + ADDR_W'(cc_c);
    rd_data_c  = interior_c ? mem[rd_addr_c] : '0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = PRIME;
          count_d = 16'd0;
          busy_d  = 1'b1;
        end
      end
      PRIME: begin
        load_c  = 1'b1;
        valid_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (fire_c) begin
          count_d = count + 16'd1;
          if (out_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      row_d  = ld_row_c;
      col_d  = ld_col_c;
      data_d = rd_data_c;
      last_d = (ld_row_c == 8'(FH - 1)) && (ld_col_c == 8'(FW - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wr_err     <= 1'b0;
      out_data   <= '0;
      out_row    <= 8'd0;
      out_col    <= 8'd0;
      count      <= 16'd0;
    end else begin
      state_q    <= state_d;
      out_valid  <= valid_d;
      out_last   <= last_d;
      busy       <= busy_d;
      frame_done <= done_d;
      wr_err     <= wr_en && !wr_ok_c;
      out_data   <= data_d;
      out_row    <= row_d;
      out_col    <= col_d;
      count      <= count_d;
    end
  end

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Directed bench: one default instance and one PAD=1 instance, ramp image data.
module tb_cnn_pixel_streamer;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, sel, out_ready;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  logic       a_valid, a_last, a_busy, a_done, a_wr_err;
  logic [7:0] a_data, a_row, a_col;
  logic [15:0] a_count;
  logic       b_valid, b_last, b_busy, b_done, b_wr_err;
  logic [7:0] b_data, b_row, b_col;
  logic [15:0] b_count;

  logic       m_valid, m_last, m_busy, m_done, m_wr_err;
  logic [7:0] m_data, m_row, m_col;
  logic [15:0] m_count;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int cap [0:899];

  always #5 clk = ~clk;

  cnn_pixel_streamer #(.PAD(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start && !sel), .out_ready(out_ready), .out_valid(a_valid),
    .out_data(a_data), .out_row(a_row), .out_col(a_col), .out_last(a_last),
    .busy(a_busy), .frame_done(a_done), .count(a_count), .wr_err(a_wr_err)
  );

  cnn_pixel_streamer #(.PAD(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start && sel), .out_ready(out_ready), .out_valid(b_valid),
    .out_data(b_data), .out_row(b_row), .out_col(b_col), .out_last(b_last),
    .busy(b_busy), .frame_done(b_done), .count(b_count), .wr_err(b_wr_err)
  );

  assign m_valid  = sel ? b_valid  : a_valid;
  assign m_last   = sel ? b_last   : a_last;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_wr_err = sel ? b_wr_err : a_wr_err;
  assign m_data   = sel ? b_data   : a_data;
  assign m_row    = sel ? b_row    : a_row;
  assign m_col    = sel ? b_col    : a_col;
  assign m_count  = sel ? b_count  : a_count;

  always @(posedge clk) if (a_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_pix(input int beat, input int pad);
    int fw, r, c;
    fw = 28 + 2 * pad;
    r  = beat / fw;
    c  = beat % fw;
    if (r < pad || r >= pad + 28 || c < pad || c >= pad + 28) return 0;
    return ((r - pad) * 28 + (c - pad)) % 256;
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("prime_valid", int'(m_valid), 0);
    check("prime_busy", int'(m_busy), 1);
    check("prime_count", int'(m_count), 0);
    @(negedge clk);
    check("first_valid", int'(m_valid), 1);
  endtask

  // mode 0: ready high, 1: toggling with a long stall, 2: write while busy, 3: reset at beat 300
  task automatic stream_body(input int mode, input int pad);
    int fw, nexp, beat, cyc, bad, lastcnt, lastbad, stallbad, hold;
    bit r, prev_stall, wr_pending, wr_done, aborted;
    logic [7:0] sd, sr, sc;
    logic sl;
    fw = 28 + 2 * pad; nexp = fw * fw;
    beat = 0; cyc = 0; bad = 0; lastcnt = 0; lastbad = 0; stallbad = 0; hold = 0;
    prev_stall = 0; wr_pending = 0; wr_done = 0; aborted = 0;
    sd = 0; sr = 0; sc = 0; sl = 0;
    while (beat < nexp && cyc < 5000) begin
      if (wr_pending) begin
        check("wr_err_busy", int'(m_wr_err), 1);
        check("busy_during_wr", int'(m_busy), 1);
        wr_en = 1'b0;
        wr_pending = 0;
      end
      if (prev_stall && (m_data != sd || m_row != sr || m_col != sc || m_last != sl)) stallbad++;
      if (mode == 1) begin
        if (beat == 100 && hold < 5) begin r = 0; hold++; end
        else r = (cyc % 2 == 0);
      end else r = 1;
      if (mode == 2 && beat == 50 && !wr_done) begin
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA; wr_pending = 1; wr_done = 1;
      end
      if (mode == 3 && beat == 300) begin
        rst = 1'b0; aborted = 1;
        break;
      end
      out_ready = r;
      if (m_valid && r) begin
        cap[beat] = int'(m_data);
        if (int'(m_data) != exp_pix(beat, pad) || int'(m_row) != beat / fw ||
            int'(m_col) != beat % fw) bad++;
        if (m_last) begin
          lastcnt++;
          if (beat != nexp - 1) lastbad++;
        end
        beat++;
      end
      prev_stall = m_valid && !r;
      sd = m_data; sr = m_row; sc = m_col; sl = m_last;
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      check("abort_valid", int'(m_valid), 0);
      check("abort_busy", int'(m_busy), 0);
      check("abort_count", int'(m_count), 0);
      check("abort_done", int'(m_done), 0);
      @(negedge clk);
      check("abort_done_late", int'(m_done), 0);
      check("abort_idle", int'(m_busy), 0);
    end else begin
      check("beats", beat, nexp);
      check("seq_bad", bad, 0);
      check("last_cnt", lastcnt, 1);
      check("last_pos", lastbad, 0);
      if (mode == 1) check("stall_stable", stallbad, 0);
      check("frame_done", int'(m_done), 1);
      check("done_busy", int'(m_busy), 0);
      check("done_valid", int'(m_valid), 0);
      check("count_final", int'(m_count), nexp);
    end
  endtask

  task automatic run_frame(input int mode, input int pad);
    start_pulse();
    stream_body(mode, pad);
  endtask

  initial begin
    int fd0, zsum;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; sel = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(a_valid), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_count", int'(a_count), 0);
    check("rst_fields", int'(a_data) + int'(a_row) + int'(a_col) + int'(a_last), 0);
    check("rst_flags", int'(a_done) + int'(a_wr_err), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 784; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("ramp_wr_err", int'(a_wr_err), 0);

    // Padded instance
    sel = 1'b1;
    @(negedge clk);
    run_frame(0, 1);
    zsum = 0;
    for (int i = 0; i < 31; i++) zsum += cap[i];
    check("pad_top_zero", zsum, 0);
    check("pad_b31", cap[31], 0);
    check("pad_b32", cap[32], 1);
    check("pad_last_int", cap[868], 8'h0F);
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Basic frame
    run_frame(0, 0);
    @(negedge clk);
    check("done_pulse_end", int'(a_done), 0);
    check("count_hold", int'(a_count), 784);

    // Backpressure
    run_frame(1, 0);
    @(negedge clk);

    // Dropped writes
    run_frame(2, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 10'd784; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_err_range", int'(a_wr_err), 1);
    check("wr_err_busy0", int'(a_busy), 0);
    @(negedge clk);
    check("wr_err_pulse", int'(a_wr_err), 0);
    run_frame(0, 0);
    check("buf5_kept", cap[5], 5);
    @(negedge clk);

    // Reset mid-frame, then replay
    fd0 = fd_cnt;
    run_frame(3, 0);
    @(negedge clk);
    check("abort_no_fd", fd_cnt - fd0, 0);
    run_frame(0, 0);
    @(negedge clk);

    // Back-to-back frames
    fd0 = fd_cnt;
    run_frame(0, 0);
    start_pulse();
    stream_body(0, 0);
    repeat (2) @(negedge clk);
    check("b2b_fd_cnt", fd_cnt - fd0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
